// File: rtl/kmp_matcher.sv
// KMP string matcher: scans str for the first occurrence of pat, doing one byte compare per cycle.
// Define SME_EARLY_EXIT_EN to end a scan as soon as the remaining string is shorter than the remaining pattern.

`ifndef BYTE
`define BYTE 8
`endif
`ifndef MAX_STRING
`define MAX_STRING 32
`endif
`ifndef MAX_STR_ADD
`define MAX_STR_ADD 5
`endif
`ifndef MAX_PATTERN
`define MAX_PATTERN 8
`endif
`ifndef MAX_PAT_ADD
`define MAX_PAT_ADD 3
`endif

module kmp_matcher (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_valid,
  input  logic [`MAX_STRING*`BYTE-1:0]       str,
  input  logic [`MAX_PATTERN*`BYTE-1:0]      pat,
  input  logic [`MAX_STR_ADD-1:0]            str_last_idx,
  input  logic [`MAX_PAT_ADD-1:0]            pat_last_idx,
  input  logic [`MAX_PAT_ADD*`MAX_PATTERN-1:0] fail_func,
  output logic                               o_valid,
  output logic                               o_match,
  output logic [`MAX_STR_ADD-1:0]            o_match_idx,
  output logic                               o_busy
);

  localparam int SA = `MAX_STR_ADD;
  localparam int PA = `MAX_PAT_ADD;
  localparam int SW = SA + 1;
  localparam int PW = PA + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] i_r, i_n, str_last_r, str_last_n;
  logic [PW-1:0] q_r, q_n, pat_last_r, pat_last_n;
  logic          match_r, match_n;
  logic [SA-1:0] idx_r, idx_n;

  logic [`BYTE-1:0] str_byte, pat_byte;
  logic [PA-1:0]    q_prev, ff_entry;

  // i and q never exceed their latched last indices, so the low bits are always a valid byte select.
  assign str_byte = str[int'(i_r[SA-1:0]) * `BYTE +: `BYTE];
  assign pat_byte = pat[int'(q_r[PA-1:0]) * `BYTE +: `BYTE];
  assign q_prev   = q_r[PA-1:0] - PA'(1);
  assign ff_entry = fail_func[int'(q_prev) * PA +: PA];

`ifdef SME_EARLY_EXIT_EN
  localparam int DW = (SW > PW) ? SW : PW;
  logic [DW-1:0] str_rem, pat_rem;
  assign str_rem = DW'(str_last_r) - DW'(i_r);
  assign pat_rem = DW'(pat_last_r) - DW'(q_r);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i_r        <= '0;
      q_r        <= '0;
      str_last_r <= '0;
      pat_last_r <= '0;
      match_r    <= 1'b0;
      idx_r      <= '0;
    end else begin
      state      <= state_n;
      i_r        <= i_n;
      q_r        <= q_n;
      str_last_r <= str_last_n;
      pat_last_r <= pat_last_n;
      match_r    <= match_n;
      idx_r      <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    i_n        = i_r;
    q_n        = q_r;
    str_last_n = str_last_r;
    pat_last_n = pat_last_r;
    match_n    = match_r;
    idx_n      = idx_r;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_n    = SCAN;
          i_n        = '0;
          q_n        = '0;
          str_last_n = SW'(str_last_idx);
          pat_last_n = PW'(pat_last_idx);
          match_n    = 1'b0;
          idx_n      = '0;
        end
      end
      SCAN: begin
`ifdef SME_EARLY_EXIT_EN
        if (str_rem < pat_rem) begin
          state_n = DONE;
        end else
`endif
        if (str_byte == pat_byte) begin
          if (q_r == pat_last_r) begin
            state_n = DONE;
            match_n = 1'b1;
            idx_n   = SA'(i_r - SW'(pat_last_r));
          end else if (i_r == str_last_r) begin
            state_n = DONE;
          end else begin
            i_n = i_r + SW'(1);
            q_n = q_r + PW'(1);
          end
        end else if (q_r != '0) begin
          // Fall back along the border chain; the string position stays put.
          q_n = PW'(ff_entry);
        end else if (i_r == str_last_r) begin
          state_n = DONE;
        end else begin
          i_n = i_r + SW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_valid     = (state == DONE);
  assign o_match     = o_valid & match_r;
  assign o_match_idx = o_valid ? idx_r : '0;
  assign o_busy      = (state != IDLE);

endmodule
